// File: rtl/dense2_serial_mac_if.sv
// dense2_serial_mac_if: stream-in, ROM and stream-out bundle
// for the second dense layer.
interface dense2_serial_mac_if #(
  parameter int DW      = 16,
  parameter int WADDR_W = 14,
  parameter int BADDR_W = 7
) ();

  logic               frame_start_in;
  logic               frame_end_in;
  logic               valid_in;
  logic [DW-1:0]      data_in;
  logic [WADDR_W-1:0] w_addr;
  logic [DW-1:0]      w_data;
  logic [BADDR_W-1:0] b_addr;
  logic [DW-1:0]      b_data;
  logic               busy;
  logic               frame_start_out;
  logic               frame_end_out;
  logic               valid;
  logic [DW-1:0]      dense_out;
  logic               len_err;
  logic               drop_err;

  modport master (
    output frame_start_in,
    output frame_end_in,
    output valid_in,
    output data_in,
    output w_data,
    output b_data,
    input  w_addr,
    input  b_addr,
    input  busy,
    input  frame_start_out,
    input  frame_end_out,
    input  valid,
    input  dense_out,
    input  len_err,
    input  drop_err
  );

  modport slave (
    input  frame_start_in,
    input  frame_end_in,
    input  valid_in,
    input  data_in,
    input  w_data,
    input  b_data,
    output w_addr,
    output b_addr,
    output busy,
    output frame_start_out,
    output frame_end_out,
    output valid,
    output dense_out,
    output len_err,
    output drop_err
  );

endinterface

// File: rtl/dense2_serial_mac.sv
// dense2_serial_mac: buffers one N_IN frame, then runs a single
// time-multiplexed MAC per output against external ROMs.
module dense2_serial_mac #(
  parameter int N_IN    = 120,
  parameter int N_OUT   = 84,
  parameter int DW      = 16,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 39,
  parameter int WADDR_W = 14,
  parameter int BADDR_W = 7
) (
  input logic              clk,
  input logic              rst_n,
  dense2_serial_mac_if.slave bus
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = $clog2(N_IN + 2);
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int SW = ACC_W + 1;

  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DW - 1) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE
  } state_t;

  state_t                    state_q;
  logic [CW-1:0]             in_cnt_q;
  logic [CW-1:0]             k_q;
  logic [JW-1:0]             j_q;
  logic [IW-1:0]             rd_k_q;
  logic                      mac_en_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DW-1:0]      bias_q;
  logic signed [DW-1:0]      buf_q [N_IN];

  logic [WADDR_W-1:0]        w_addr_q;
  logic                      busy_q;
  logic                      fs_out_q;
  logic                      fe_out_q;
  logic                      valid_q;
  logic [DW-1:0]             dout_q;
  logic                      len_err_q;
  logic                      drop_err_q;

  logic                      beat;
  logic                      sof;
  logic                      eof;
  logic                      start_wr;
  logic                      data_wr;
  logic                      issue;
  logic                      fin;
  logic                      last_j;

  logic signed [DW-1:0]      op_a;
  logic signed [DW-1:0]      op_b;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [SW-1:0]      acc_x;
  logic signed [SW-1:0]      bias_x;
  logic signed [SW-1:0]      sum;
  logic signed [SW-1:0]      sh;
  logic [DW-1:0]             dout_d;

  assign beat     = bus.valid_in;
  assign sof      = beat & bus.frame_start_in;
  assign eof      = beat & bus.frame_end_in;
  assign start_wr = sof && (state_q != COMPUTE);
  assign data_wr  = beat && !bus.frame_start_in &&
                    (state_q == LOAD) &&
                    (in_cnt_q < CW'(N_IN));
  assign issue    = (state_q == COMPUTE) && (k_q < CW'(N_IN));
  assign fin      = (state_q == COMPUTE) && (k_q == CW'(N_IN + 1));
  assign last_j   = (j_q == JW'(N_OUT - 1));

  assign bus.w_addr          = w_addr_q;
  assign bus.b_addr          = BADDR_W'(j_q);
  assign bus.busy            = busy_q;
  assign bus.frame_start_out = fs_out_q;
  assign bus.frame_end_out   = fe_out_q;
  assign bus.valid           = valid_q;
  assign bus.dense_out       = dout_q;
  assign bus.len_err         = len_err_q;
  assign bus.drop_err        = drop_err_q;

  // MAC product, Q.16 bias alignment, floor shift and saturation
  always_comb begin
    op_a   = buf_q[rd_k_q];
    op_b   = bus.w_data;
    prod   = op_a * op_b;
    acc_d  = acc_q + {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
    acc_x  = {acc_q[ACC_W-1], acc_q};
    bias_x = {{(SW - DW){bias_q[DW-1]}}, bias_q};
    sum    = acc_x + (bias_x <<< FRAC);
    sh     = sum >>> FRAC;
    dout_d = sh[DW-1:0];
    if (sh > MAXV) begin
      dout_d = {1'b0, {(DW-1){1'b1}}};
    end else if (sh < MINV) begin
      dout_d = {1'b1, {(DW-1){1'b0}}};
    end
  end

  // Frame buffer: zeroed on frame start so short frames pad with 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        buf_q[i] <= '0;
      end
    end else if (start_wr) begin
      for (int i = 0; i < N_IN; i++) begin
        buf_q[i] <= (i == 0) ? bus.data_in : '0;
      end
    end else if (data_wr) begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_cnt_q == CW'(i)) begin
          buf_q[i] <= bus.data_in;
        end
      end
    end
  end

  // Control FSM with registered outputs, counters and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_cnt_q   <= '0;
      k_q        <= '0;
      j_q        <= '0;
      rd_k_q     <= '0;
      mac_en_q   <= 1'b0;
      acc_q      <= '0;
      bias_q     <= '0;
      w_addr_q   <= '0;
      busy_q     <= 1'b0;
      fs_out_q   <= 1'b0;
      fe_out_q   <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      len_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      fs_out_q <= 1'b0;
      fe_out_q <= 1'b0;
      mac_en_q <= issue;
      rd_k_q   <= IW'(k_q);
      case (state_q)
        IDLE: begin
          if (sof) begin
            in_cnt_q <= CW'(1);
            busy_q   <= 1'b1;
            if (eof) begin
              if (N_IN != 1) len_err_q <= 1'b1;
              state_q  <= COMPUTE;
              k_q      <= '0;
              j_q      <= '0;
              w_addr_q <= '0;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (sof) begin
            in_cnt_q  <= CW'(1);
            len_err_q <= 1'b1;
          end else if (beat) begin
            if (in_cnt_q < CW'(N_IN)) begin
              in_cnt_q <= in_cnt_q + CW'(1);
            end else begin
              len_err_q <= 1'b1;
            end
            if (eof && (in_cnt_q != CW'(N_IN - 1))) begin
              len_err_q <= 1'b1;
            end
          end
          if (eof) begin
            state_q  <= COMPUTE;
            k_q      <= '0;
            j_q      <= '0;
            w_addr_q <= '0;
          end
        end
        COMPUTE: begin
          if (sof) drop_err_q <= 1'b1;
          if (mac_en_q) begin
            acc_q <= acc_d;
          end else if (issue && (k_q == '0)) begin
            acc_q <= '0;
          end
          if (issue) w_addr_q <= w_addr_q + WADDR_W'(1);
          if (k_q == CW'(N_IN)) bias_q <= bus.b_data;
          if (fin) begin
            dout_q   <= dout_d;
            valid_q  <= 1'b1;
            fs_out_q <= (j_q == '0);
            fe_out_q <= last_j;
            k_q      <= '0;
            if (last_j) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              j_q      <= '0;
              w_addr_q <= '0;
              in_cnt_q <= '0;
            end else begin
              j_q <= j_q + JW'(1);
            end
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense2_serial_mac.sv
// tb_dense2_serial_mac: scoreboard bench with registered ROM models
// and a bit-true reference model of the dense layer.
module tb_dense2_serial_mac;

  localparam int N_IN    = 120;
  localparam int N_OUT   = 84;
  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int WADDR_W = 14;
  localparam int BADDR_W = 7;
  localparam int BUDGET  = 11000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dense2_serial_mac_if #(
    .DW(DW), .WADDR_W(WADDR_W), .BADDR_W(BADDR_W)
  ) bus ();

  dense2_serial_mac #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC),
    .ACC_W(39), .WADDR_W(WADDR_W), .BADDR_W(BADDR_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic          fs;
    logic          fe;
    logic [DW-1:0] d;
  } out_t;

  logic signed [DW-1:0] inp   [N_IN];
  logic signed [DW-1:0] w_rom [N_IN*N_OUT];
  logic signed [DW-1:0] b_rom [N_OUT];

  out_t exp_q[$];
  out_t got_q[$];
  int   got_cyc[$];
  logic got_busy[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // registered ROMs: data one cycle after address
  always @(posedge clk) begin
    bus.w_data <= (int'(bus.w_addr) < N_IN*N_OUT) ? w_rom[bus.w_addr] : '0;
    bus.b_data <= (int'(bus.b_addr) < N_OUT) ? b_rom[bus.b_addr] : '0;
  end

  task automatic build_expected(input int len);
    longint acc, s;
    out_t e;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int k = 0; k < len && k < N_IN; k++) begin
        acc += longint'(inp[k]) * longint'(w_rom[j*N_IN + k]);
      end
      s = (acc + (longint'(b_rom[j]) <<< FRAC)) >>> FRAC;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      e.fs = (j == 0);
      e.fe = (j == N_OUT - 1);
      e.d  = s[DW-1:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int len, output int t_end);
    t_end = 0;
    for (int b = 0; b < len; b++) begin
      @(negedge clk);
      bus.valid_in       = 1'b1;
      bus.frame_start_in = (b == 0);
      bus.frame_end_in   = (b == len - 1);
      bus.data_in        = inp[b];
      if (b == len - 1) t_end = cyc;
    end
    @(negedge clk);
    bus.valid_in       = 1'b0;
    bus.frame_start_in = 1'b0;
    bus.frame_end_in   = 1'b0;
  endtask

  task automatic capture(input int max_n, input int drop_at,
                         input int budget);
    bit dropped = 1'b0;
    got_q.delete();
    got_cyc.delete();
    got_busy.delete();
    for (int c = 0; c < budget && got_q.size() < max_n; c++) begin
      @(negedge clk);
      bus.valid_in       = 1'b0;
      bus.frame_start_in = 1'b0;
      if (bus.valid) begin
        got_q.push_back({bus.frame_start_out, bus.frame_end_out,
                         bus.dense_out});
        got_cyc.push_back(cyc);
        got_busy.push_back(bus.busy);
      end
      if (drop_at >= 0 && !dropped && got_q.size() == drop_at) begin
        bus.valid_in       = 1'b1;
        bus.frame_start_in = 1'b1;
        bus.data_in        = 16'h1234;
        dropped            = 1'b1;
      end
    end
    bus.valid_in       = 1'b0;
    bus.frame_start_in = 1'b0;
  endtask

  task automatic test_reset;
    logic [63:0] obs;
    bus.valid_in       = 1'b0;
    bus.frame_start_in = 1'b0;
    bus.frame_end_in   = 1'b0;
    bus.data_in        = '0;
    rst_n              = 1'b0;
    repeat (3) @(negedge clk);
    obs = 64'({bus.busy, bus.valid, bus.frame_start_out,
               bus.frame_end_out, bus.dense_out, bus.len_err,
               bus.drop_err, bus.w_addr, bus.b_addr});
    n_cmp++;
    if (obs !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_in: outputs=%h want 0", obs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    obs = 64'({bus.busy, bus.valid, bus.dense_out, bus.len_err,
               bus.drop_err, bus.w_addr, bus.b_addr});
    n_cmp++;
    if (obs !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_out: outputs=%h want 0", obs);
    end
    // stray beat without frame_start must be ignored
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.data_in  = 16'h0100;
    @(negedge clk);
    bus.valid_in = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_ignore: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_nominal;
    int t_end;
    out_t g, e;
    for (int k = 0; k < N_IN; k++) inp[k] = 16'sh0100;
    for (int i = 0; i < N_IN*N_OUT; i++) w_rom[i] = 16'sh0100;
    for (int j = 0; j < N_OUT; j++) b_rom[j] = 16'sh0000;
    exp_q.delete();
    send_frame(N_IN, t_end);
    for (int j = 0; j < N_OUT; j++) begin
      e.fs = (j == 0);
      e.fe = (j == N_OUT - 1);
      e.d  = 16'h7800;
      exp_q.push_back(e);
    end
    capture(N_OUT, -1, BUDGET);
    n_cmp++;
    if (got_q.size() !== N_OUT) begin
      n_bad++;
      $display("FAIL nominal_count: got %0d want %0d",
               got_q.size(), N_OUT);
    end
    if (got_q.size() == N_OUT) begin
      n_cmp++;
      if (got_cyc[0] - t_end !== N_IN + 3) begin
        n_bad++;
        $display("FAIL nominal_latency: got %0d want %0d",
                 got_cyc[0] - t_end, N_IN + 3);
      end
      for (int i = 1; i < N_OUT; i++) begin
        n_cmp++;
        if (got_cyc[i] - got_cyc[i-1] !== N_IN + 2) begin
          n_bad++;
          $display("FAIL nominal_period[%0d]: got %0d want %0d",
                   i, got_cyc[i] - got_cyc[i-1], N_IN + 2);
        end
      end
      n_cmp++;
      if ({got_busy[0], got_busy[N_OUT-1]} !== 2'b10) begin
        n_bad++;
        $display("FAIL nominal_busy: first/last=%b%b want 10",
                 got_busy[0], got_busy[N_OUT-1]);
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL nominal_out[%0d]: got fs=%b fe=%b d=%h want fs=%b fe=%b d=%h",
                 i, g.fs, g.fe, g.d, e.fs, e.fe, e.d);
      end
    end
    n_cmp++;
    if ({bus.len_err, bus.drop_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL nominal_flags: len/drop=%b%b want 00",
               bus.len_err, bus.drop_err);
    end
    exp_q.delete();
  endtask

  task automatic test_saturation_drop;
    int t_end;
    out_t g, e;
    for (int k = 0; k < N_IN; k++) inp[k] = 16'sh0100;
    for (int j = 0; j < N_OUT; j++) begin
      for (int k = 0; k < N_IN; k++) begin
        w_rom[j*N_IN + k] = (j % 2 == 0) ? 16'sh0200 : -16'sh0200;
      end
      b_rom[j] = 16'sh0000;
    end
    exp_q.delete();
    send_frame(N_IN, t_end);
    build_expected(N_IN);
    capture(N_OUT, 20, BUDGET);
    n_cmp++;
    if (got_q.size() !== N_OUT) begin
      n_bad++;
      $display("FAIL sat_count: got %0d want %0d", got_q.size(), N_OUT);
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e || g.d !== ((i % 2 == 0) ? 16'h7FFF : 16'h8000)) begin
        n_bad++;
        $display("FAIL sat_out[%0d]: got fs=%b fe=%b d=%h want fs=%b fe=%b d=%h",
                 i, g.fs, g.fe, g.d, e.fs, e.fe, e.d);
      end
    end
    n_cmp++;
    if ({bus.drop_err, bus.len_err} !== 2'b10) begin
      n_bad++;
      $display("FAIL drop_flag: drop/len=%b%b want 10",
               bus.drop_err, bus.len_err);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int t_end;
    out_t g, e;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy: got %b want 0", bus.busy);
    end
    for (int k = 0; k < N_IN; k++) inp[k] = 16'sh0001;
    for (int i = 0; i < N_IN*N_OUT; i++) w_rom[i] = 16'sh0080;
    for (int j = 0; j < N_OUT; j++) b_rom[j] = DW'(j * 256);
    exp_q.delete();
    send_frame(N_IN, t_end);
    build_expected(N_IN);
    capture(N_OUT, -1, BUDGET);
    n_cmp++;
    if (got_q.size() !== N_OUT) begin
      n_bad++;
      $display("FAIL bias_count: got %0d want %0d", got_q.size(), N_OUT);
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e || g.d !== DW'(i * 256 + 60)) begin
        n_bad++;
        $display("FAIL bias_out[%0d]: got fs=%b fe=%b d=%h want fs=%b fe=%b d=%h",
                 i, g.fs, g.fe, g.d, e.fs, e.fe, e.d);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int t_end;
    out_t g, e;
    logic [63:0] obs;
    for (int k = 0; k < N_IN; k++) begin
      inp[k] = DW'($urandom_range(0, 1023)) - 16'sd512;
    end
    for (int i = 0; i < N_IN*N_OUT; i++) w_rom[i] = -16'sh0080;
    for (int j = 0; j < N_OUT; j++) b_rom[j] = DW'(j * 256);
    exp_q.delete();
    send_frame(N_IN, t_end);
    build_expected(N_IN);
    capture(40, -1, BUDGET);
    for (int i = 0; i < 40; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL pre_reset_out[%0d]: got d=%h want d=%h",
                 i, g.d, e.d);
      end
    end
    rst_n = 1'b0;
    #1;
    obs = 64'({bus.busy, bus.valid, bus.frame_start_out,
               bus.frame_end_out, bus.dense_out, bus.len_err,
               bus.drop_err, bus.w_addr, bus.b_addr});
    n_cmp++;
    if (obs !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h want 0", obs);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    capture(1, -1, 300);
    n_cmp++;
    if (got_q.size() !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_novalid: got %0d pulses want 0",
               got_q.size());
    end
    for (int k = 0; k < N_IN; k++) inp[k] = 16'sh0001;
    send_frame(N_IN, t_end);
    build_expected(N_IN);
    capture(N_OUT, -1, BUDGET);
    n_cmp++;
    if (got_q.size() !== N_OUT) begin
      n_bad++;
      $display("FAIL fresh_count: got %0d want %0d", got_q.size(), N_OUT);
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e || g.d !== DW'(i * 256 - 60)) begin
        n_bad++;
        $display("FAIL fresh_out[%0d]: got fs=%b fe=%b d=%h want fs=%b fe=%b d=%h",
                 i, g.fs, g.fe, g.d, e.fs, e.fe, e.d);
      end
    end
    n_cmp++;
    if ({bus.len_err, bus.drop_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL fresh_flags: len/drop=%b%b want 00",
               bus.len_err, bus.drop_err);
    end
    exp_q.delete();
  endtask

  task automatic test_short_frame;
    int t_end;
    out_t g, e;
    for (int k = 0; k < N_IN; k++) begin
      inp[k] = DW'($urandom_range(0, 1023)) - 16'sd512;
    end
    for (int i = 0; i < N_IN*N_OUT; i++) begin
      w_rom[i] = DW'($urandom_range(0, 511)) - 16'sd256;
    end
    for (int j = 0; j < N_OUT; j++) begin
      b_rom[j] = DW'($urandom_range(0, 4095)) - 16'sd2048;
    end
    exp_q.delete();
    send_frame(100, t_end);
    build_expected(100);
    capture(N_OUT, -1, BUDGET);
    n_cmp++;
    if (bus.len_err !== 1'b1) begin
      n_bad++;
      $display("FAIL short_len_err: got %b want 1", bus.len_err);
    end
    n_cmp++;
    if (got_q.size() !== N_OUT) begin
      n_bad++;
      $display("FAIL short_count: got %0d want %0d", got_q.size(), N_OUT);
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (got_q.size() == 0 || exp_q.size() == 0) break;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL short_out[%0d]: got fs=%b fe=%b d=%h want fs=%b fe=%b d=%h",
                 i, g.fs, g.fe, g.d, e.fs, e.fe, e.d);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation_drop();
    test_back_to_back();
    test_reset_mid();
    test_short_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dense2_serial_mac.md
Name: dense2_serial_mac

Overview:
- Second fully connected layer. Sits directly downstream of the dense1 stage.
- Consumes its serial stream of N_IN sigmoid-activated 16-bit values per frame and buffers the whole frame.
- Computes N_OUT outputs with a single time-multiplexed MAC against external weight and bias ROMs.
- Emits the N_OUT biased sums serially with frame_start/frame_end framing, ready for the next activation stage.

Parameters:
- N_IN, 120, input vector length per frame
- N_OUT, 84, output vector length per frame
- DW, 16, data/weight/bias width (signed fixed point)
- FRAC, 8, fractional bits of data, weights and bias (Q7.8)
- ACC_W, 39, accumulator width (2*DW + ceil(log2(N_IN)))
- WADDR_W, 14, weight ROM address width (must be ≥ ceil(log2(N_IN*N_OUT)))
- BADDR_W, 7, bias ROM address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active low
- frame_start_in  in  1  high with first valid beat of a frame
- frame_end_in  in  1  high with last valid beat of a frame
- valid_in  in  1  data_in qualifier
- data_in  in  DW  signed input element
- w_addr  out  WADDR_W  weight ROM address; row-major, j*N_IN + k
- w_data  in  DW  signed weight; valid exactly 1 cycle after w_addr
- b_addr  out  BADDR_W  bias ROM address (j)
- b_data  in  DW  signed bias; valid 1 cycle after b_addr
- busy  out  1  high in LOAD/COMPUTE
- frame_start_out  out  1  high with output j=0
- frame_end_out  out  1  high with output j=N_OUT-1
- valid  out  1  one-cycle pulse per output element
- dense_out  out  DW  signed output element
- len_err  out  1  sticky: frame length ≠ N_IN
- drop_err  out  1  sticky: frame_start_in arrived while COMPUTE

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0, accumulator 0, error flags cleared. Reset mid-frame or mid-compute aborts immediately; the partial frame is discarded and never emitted.

FSM states: IDLE, LOAD, COMPUTE.

IDLE
- valid_in & frame_start_in writes data_in to buf[0], sets in_cnt=1 and goes to LOAD.
- If frame_end_in is also high in that beat (length-1 frame), it is treated as the end of the frame.
- valid_in without frame_start_in is ignored.

LOAD
- Each valid_in writes buf[in_cnt] and increments in_cnt.
- Beats with in_cnt ≥ N_IN are discarded and set len_err.
- valid_in & frame_end_in:
  - if the final count ≠ N_IN, set len_err;
  - unwritten buf entries read as 0 (buffer is cleared on frame_start);
  - go to COMPUTE next cycle.
- frame_start_in in LOAD restarts the frame at index 0 and sets len_err.

COMPUTE
- Outer counter j = 0..N_OUT-1, inner counter k = 0..N_IN-1.
- One weight address is issued per cycle: w_addr = j*N_IN + k.
- b_addr = j is issued in the same cycle as k = N_IN-1.
- On the cycle after each issue, acc += buf[k] * w_data (full DW*2 product, sign-extended to ACC_W). The acc is cleared at each k = 0 issue.
- Finalize happens one cycle after the last accumulate:
  - s = (acc + sign_ext(b_data) << FRAC) >>> FRAC (arithmetic shift, floor);
  - saturate to [-32768, 32767];
  - register into dense_out with a valid pulse.
- Per-output period is exactly N_IN + 2 cycles, with no overlap.
- Latency from the frame_end_in beat to the first valid is N_IN + 3 cycles. Total compute is N_OUT*(N_IN+2) cycles.
- After the j = N_OUT-1 output, return to IDLE. busy drops in the same cycle as that last valid.
- frame_start_in during COMPUTE: the frame is ignored, drop_err is set, and computation continues undisturbed.
- dense_out holds its last value between valid pulses. frame_start_out and frame_end_out are only asserted together with valid.
- N_OUT = 1: frame_start_out and frame_end_out are asserted on the same beat.
- Error flags clear only on reset.

Test Plan:
- Nominal frame: 120 beats of 0x0100 (1.0); ROM all weights 0x0100, biases 0x0000.
  - Expect 84 valid pulses, each dense_out = 0x7800.
  - frame_start_out on the first pulse, frame_end_out on the 84th.
  - First valid exactly 123 cycles after the frame_end_in beat; pulses spaced 122 cycles apart.
- Saturation: inputs 0x0100, weights 0x0200 (sum 240.0) → every output 0x7FFF. Weights 0xFE00 → every output 0x8000.
- Bias/rounding:
  - input[k]=0x0001, weights 0x0080 (0.5), bias[j]=j*0x0100 → output j = j*0x0100 + 0x003C (120*0.5 LSB = 60 LSB = 0x3C).
  - Negative case: weights 0xFF80 → output 0x...FFC4 + bias, floor applied.
- Short frame: frame_end_in on beat 100.
  - len_err is set.
  - Elements 100..119 contribute 0.
  - Outputs match the reference model computed with zero-padding.
- Drop: frame_start_in pulsed mid-COMPUTE.
  - drop_err is set.
  - The current 84 outputs are unchanged.
  - A frame started after busy falls is processed normally.
- Reset: rst_n asserted during COMPUTE at j=40.
  - All outputs 0 within the same cycle, with no further valid.
  - A fresh frame afterwards yields a correct full 84-element output.
